// File: rtl/neurotransmitter_release.sv
// Presynaptic release unit: spike -> tmax plateau, then multiplicative
// clearance to zero, streamed over a valid/ready handshake.
module neurotransmitter_release #(
  parameter int N              = 32,
  parameter int Q              = 16,
  parameter int RELEASE_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike,
  input  logic [N-1:0]     tmax,
  input  logic [N-1:0]     clear_constant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     t,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    RELEASE,
    DECAY
  } state_e;

  localparam logic [N-1:0] ONE   = N'(1) << Q;
  localparam logic [N-1:0] ONE_M = ONE - N'(1);

  state_e           state_q, state_d;
  logic [N-1:0]     t_q, t_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [N-1:0]     tmax_c;
  logic [N-1:0]     c_c;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     dec;
  logic             xfer;
  logic             unused_prod;

  // Clamps keep t non-negative and c' below 1.0 so decay always hits 0.
  always_comb begin
    tmax_c = tmax[N-1] ? '0 : tmax;
    c_c    = clear_constant;
    if (clear_constant[N-1])
      c_c = '0;
    else if (clear_constant >= ONE)
      c_c = ONE_M;
  end

  assign prod = $signed(t_q) * $signed(c_c);
  assign dec  = prod[N+Q-1:Q];
  assign xfer = valid_q & out_ready;

  assign unused_prod = ^{prod[2*N-1:N+Q], prod[Q-1:0]};

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (spike) begin
          state_d = RELEASE;
          t_d     = tmax_c;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE, DECAY: begin
        if (xfer) begin
          if (pend_q | spike) begin
            state_d = RELEASE;
            t_d     = tmax_c;
            cnt_d   = CNT_W'(1);
            pend_d  = 1'b0;
          end else if (state_q == RELEASE) begin
            if (cnt_q < CNT_W'(RELEASE_CYCLES)) begin
              t_d   = tmax_c;
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = DECAY;
              t_d     = dec;
            end
          end else if (t_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            t_d     = '0;
          end else begin
            t_d = dec;
          end
        end else if (spike) begin
          if (!pend_q)
            pend_d = 1'b1;
          else if (drop_q != '1)
            drop_d = drop_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid  = valid_q;
  assign t          = t_q;
  assign busy       = (state_q != IDLE);
  assign drop_count = drop_q;

endmodule
